// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and read-port owner encoding for mem and mem_arbiter
package mem_arbiter_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int ADDR_WIDTH_DEF   = 10;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LS    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem.sv
// rtl/mem.sv - 16x1024 dual-port word memory, registered read, old data on read-during-write
module mem
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] ram [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[write_addr] <= data;
        end
        q <= ram[read_addr];
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store onto mem's read and write ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ready,
    output logic                  ls_valid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int             CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

    owner_t                owner;
    owner_t                next_owner;
    logic [CW-1:0]         starve_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic store;
    logic load;
    logic fetch;
    logic fetch_forced;
    logic hazard;
    logic load_win;
    logic fetch_win;

    // Requests are masked by rst_n so every ready and the write strobe drop as soon as reset asserts.
    always_comb begin
        store        = rst_n & ls_req & ls_we;
        load         = rst_n & ls_req & ~ls_we;
        fetch        = rst_n & fetch_req;
        fetch_forced = fetch & (starve_cnt == LIMIT);
        hazard       = store & fetch & (fetch_addr == ls_addr);
        load_win     = load & ~fetch_forced;
        fetch_win    = fetch & ~load_win & ~hazard;
    end

    always_comb begin
        next_owner     = OWN_NONE;
        mem_read_addr  = rd_addr_q;
        if (load_win) begin
            next_owner    = OWN_LS;
            mem_read_addr = ls_addr;
        end else if (fetch_win) begin
            next_owner    = OWN_FETCH;
            mem_read_addr = fetch_addr;
        end
        ls_ready       = store | load_win;
        fetch_ready    = fetch_win;
        mem_we         = store;
        mem_write_addr = store ? ls_addr  : wr_addr_q;
        mem_data       = store ? ls_wdata : wr_data_q;
    end

    always_comb begin
        fetch_valid = (owner == OWN_FETCH);
        ls_valid    = (owner == OWN_LS);
        fetch_data  = fetch_valid ? mem_q : '0;
        ls_rdata    = ls_valid    ? mem_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            owner <= next_owner;
            if (load_win || fetch_win) begin
                rd_addr_q <= mem_read_addr;
            end
            if (store) begin
                wr_addr_q <= ls_addr;
                wr_data_q <= ls_wdata;
            end
            // Hazard stalls count as starvation too, so a fetch cannot be held off indefinitely.
            if (fetch && !fetch_win) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter driving the real mem
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_ready;
    logic          ls_valid;
    logic [DW-1:0] ls_rdata;
    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_mem [0:15];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_mem (
        .clk(clk), .read_addr(mem_read_addr), .write_addr(mem_write_addr),
        .data(mem_data), .we(mem_we), .q(mem_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr,
                         input logic lwe, input logic [AW-1:0] la, input logic [DW-1:0] lwd);
        fetch_req  = fr;
        fetch_addr = fa;
        ls_req     = lr;
        ls_we      = lwe;
        ls_addr    = la;
        ls_wdata   = lwd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fready"}, 32'(fetch_ready), 32'd0);
        check({tag, "_lready"}, 32'(ls_ready), 32'd0);
        check({tag, "_fvalid"}, 32'(fetch_valid), 32'd0);
        check({tag, "_lvalid"}, 32'(ls_valid), 32'd0);
        check({tag, "_fdata"}, 32'(fetch_data), 32'd0);
        check({tag, "_ldata"}, 32'(ls_rdata), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_raddr"}, 32'(mem_read_addr), 32'd0);
        check({tag, "_waddr"}, 32'(mem_write_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 10'd4, 1'b1, 1'b1, 10'd6, 16'h5555);
        check_all_zero("reset");
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // Preload addresses 0..15 with known contents.
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 16'hA000 + 16'(i);
            drive(1'b0, '0, 1'b1, 1'b1, AW'(i), exp_mem[i]);
            if (i == 0) begin
                check("init_lready", 32'(ls_ready), 32'd1);
                check("init_we", 32'(mem_we), 32'd1);
                check("init_waddr", 32'(mem_write_addr), 32'd0);
            end
            tick();
        end
        idle();
        tick();

        // 1: store then load
        drive(1'b0, '0, 1'b1, 1'b1, 10'd0, 16'h0001);
        exp_mem[0] = 16'h0001;
        check("t1_store_ready", 32'(ls_ready), 32'd1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 10'd0, '0);
        check("t1_load_ready", 32'(ls_ready), 32'd1);
        check("t1_we_low", 32'(mem_we), 32'd0);
        tick();
        idle();
        check("t1_lvalid", 32'(ls_valid), 32'd1);
        check("t1_ldata", 32'(ls_rdata), 32'h0001);
        check("t1_waddr_hold", 32'(mem_write_addr), 32'd0);
        check("t1_wdata_hold", 32'(mem_data), 32'h0001);
        check("t1_raddr_hold", 32'(mem_read_addr), 32'd0);
        tick();
        check("t1_lvalid_drop", 32'(ls_valid), 32'd0);

        // 2: fetch vs load conflict, starvation guard
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 10'd5, 1'b1, 1'b0, 10'd9, '0);
            check($sformatf("t2_lready_%0d", c), 32'(ls_ready), 32'(c < 4));
            check($sformatf("t2_fready_%0d", c), 32'(fetch_ready), 32'(c == 4));
            if (c > 0) begin
                check($sformatf("t2_lvalid_%0d", c), 32'(ls_valid), 32'd1);
                check($sformatf("t2_ldata_%0d", c), 32'(ls_rdata), 32'(exp_mem[9]));
            end
            tick();
        end
        idle();
        check("t2_fvalid", 32'(fetch_valid), 32'd1);
        check("t2_fdata", 32'(fetch_data), 32'(exp_mem[5]));
        check("t2_lvalid_off", 32'(ls_valid), 32'd0);
        tick();
        drive(1'b1, 10'd5, 1'b1, 1'b0, 10'd9, '0);
        check("t2_cnt_clear_lready", 32'(ls_ready), 32'd1);
        check("t2_cnt_clear_fready", 32'(fetch_ready), 32'd0);
        tick();
        idle();
        tick();

        // 3: store and fetch in parallel
        drive(1'b1, 10'd7, 1'b1, 1'b1, 10'd3, 16'hBEEF);
        exp_mem[3] = 16'hBEEF;
        check("t3_lready", 32'(ls_ready), 32'd1);
        check("t3_fready", 32'(fetch_ready), 32'd1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 10'd3, '0);
        check("t3_fvalid", 32'(fetch_valid), 32'd1);
        check("t3_fdata", 32'(fetch_data), 32'(exp_mem[7]));
        tick();
        idle();
        check("t3_ldata", 32'(ls_rdata), 32'h0000BEEF);
        tick();

        // 4: same-address store/fetch hazard
        drive(1'b1, 10'd8, 1'b1, 1'b1, 10'd8, 16'h1234);
        exp_mem[8] = 16'h1234;
        check("t4_fready_stall", 32'(fetch_ready), 32'd0);
        check("t4_lready", 32'(ls_ready), 32'd1);
        tick();
        drive(1'b1, 10'd8, 1'b0, 1'b0, '0, '0);
        check("t4_fready_retry", 32'(fetch_ready), 32'd1);
        check("t4_fvalid_none", 32'(fetch_valid), 32'd0);
        tick();
        idle();
        check("t4_fdata", 32'(fetch_data), 32'h00001234);
        tick();

        // 5: streaming fetch 0..15
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
            check($sformatf("t5_fready_%0d", i), 32'(fetch_ready), 32'd1);
            if (i > 0) begin
                check($sformatf("t5_fvalid_%0d", i), 32'(fetch_valid), 32'd1);
                check($sformatf("t5_fdata_%0d", i), 32'(fetch_data), 32'(exp_mem[i-1]));
            end
            tick();
        end
        idle();
        check("t5_fvalid_last", 32'(fetch_valid), 32'd1);
        check("t5_fdata_last", 32'(fetch_data), 32'(exp_mem[15]));
        tick();
        check("t5_fvalid_end", 32'(fetch_valid), 32'd0);

        // 6: reset with a load in flight
        drive(1'b0, '0, 1'b1, 1'b0, 10'd2, '0);
        check("t6_lready", 32'(ls_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        idle();
        tick();
        check("t6_lvalid_rst", 32'(ls_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t6_lvalid_after", 32'(ls_valid), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 10'd2, '0);
        check("t6_reload_ready", 32'(ls_ready), 32'd1);
        tick();
        idle();
        check("t6_reload_valid", 32'(ls_valid), 32'd1);
        check("t6_reload_data", 32'(ls_rdata), 32'(exp_mem[2]));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
